memory_data_be: RTL
===================

# memory_data_be

Byte-addressable RV32 data memory: the parametrised successor to the core's word-only data RAM. It adds byte/halfword stores with lane enables, sign/zero-extending sub-word loads, misalignment detection, and a reset-triggered zero-clear sequencer. It sits in the MEM stage and is driven directly by the load/store unit. It maps to block RAM, with one read port and one write port.

## Interface

- WORD_ADDR_BITS, 10, log2 of depth in 32-bit words; depth = 2**WORD_ADDR_BITS.
- CLEAR_ON_RESET, 1, when 1 every reset runs the zero-clear sequence; when 0 reset does not touch contents.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_en  in  1  load request.
- rd_addr  in  32  load byte address.
- rd_funct3  in  3  RV32 load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- rd_data  out  32  extended load result.
- rd_valid  out  1  rd_data holds the result of the load accepted on the previous edge.
- wr_en  in  1  store request.
- wr_addr  in  32  store byte address.
- wr_funct3  in  3  RV32 store funct3: 000 SB, 001 SH, 010 SW.
- wr_data  in  32  store data; low byte/half used for SB/SH.
- busy  out  1  clear sequence in progress; requests are ignored.
- misalign  out  1  one-cycle pulse: an accepted request was misaligned or had an illegal funct3.

## Operation

- Word index is addr[WORD_ADDR_BITS+1:2]. Higher address bits are ignored, so addresses alias modulo depth.
- Alignment rules:
  - LB/LBU/SB: always aligned.
  - LH/LHU/SH: require addr[0]=0.
  - LW/SW: require addr[1:0]=00.
  - Any other funct3 value is illegal.
- Stores:
  - SB writes lane addr[1:0] with wr_data[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wr_data[15:0].
  - SW writes all four lanes.
  - Unwritten lanes are preserved.
- Loads:
  - Lane select uses the registered addr[1:0] and funct3.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW returns the full word.
- Faulting requests:
  - A misaligned or illegal store writes nothing.
  - A misaligned or illegal load gives rd_valid=0 and leaves rd_data unchanged.
  - In both cases misalign=1 on the next cycle.
  - If both ports fault together, misalign is a single 1 (OR of the two).
- State machine, two states:
  - CLEAR: busy=1. A word counter starts at 0. Each edge writes 32'h0 to mem[counter] and increments the counter. After writing word depth-1, go to READY.
  - READY: busy=0. Requests are accepted.
- Reset behaviour:
  - rst=1 forces CLEAR with counter=0 if CLEAR_ON_RESET=1; otherwise it forces READY.
  - rst asserted mid-clear restarts the sequence at word 0.
- While busy=1, rd_en/wr_en are ignored: no write, rd_valid=0, misalign=0.
- Initial contents are zero at configuration.

## Timing

- Reset values:
  - rd_data=0, rd_valid=0, misalign=0.
  - busy=CLEAR_ON_RESET, visible from the edge on which rst is sampled high.
- Clear duration: with CLEAR_ON_RESET=1, the first edge with rst=0 clears word 0. Edge N clears word N-1 and drops busy, where N=depth. The first request is accepted on edge N+1.
- Load latency is 1 cycle. A request sampled on edge k gives rd_data/rd_valid valid after edge k. rd_valid lasts one cycle unless another load follows.
- rd_data holds its value until the next accepted aligned load. Back-to-back loads run at full throughput.
- Stores commit on the sampling edge. A load on the following edge sees the new data.
- A same-word read and write on the same edge is read-first: the load returns the old word.
- misalign is valid in the cycle after the faulting request, for exactly 1 cycle.

## Test plan

- Clear: preload mem[5]=32'hDEADBEEF (CLEAR_ON_RESET=1, WORD_ADDR_BITS=4), pulse rst → busy high for exactly 16 cycles after rst falls; then LW 0x14 → rd_data=0. Also: reassert rst at clear cycle 7 → busy lasts a further 16 cycles from release.
- Byte stores and loads:
  - SW 0x100 = 32'h11223344, then SB 0x101 = 8'hA5 → LW 0x100 returns 32'h1122A544.
  - LB 0x101 returns 32'hFFFFFFA5.
  - LBU 0x101 returns 32'h000000A5.
- Halfwords: SH 0x102 = 16'h8001 → LH 0x102 = 32'hFFFF8001, LHU 0x102 = 32'h00008001, LW 0x100 = 32'h8001A544.
- Misalignment:
  - SW 0x101 → no write (LW 0x100 unchanged) and misalign=1 for one cycle.
  - LH 0x103 → rd_valid=0, misalign=1, rd_data unchanged.
  - funct3=011 → misalign=1.
- Read-first and aliasing:
  - LW and SW to 0x200 on the same edge → load returns the old word; the next LW returns the new word.
  - With WORD_ADDR_BITS=10, SW 0x1000 aliases word 0.
- Busy gating: during the clear, issue SW 0x8 = 1 and LW 0x8 → rd_valid and misalign stay 0; after the clear, LW 0x8 returns 0.

Source files
------------

// File: rtl/memory_data_be_if.sv
// -----------------------------------------------------------------------------
// memory_data_be_if
//
// Purpose:
//   Bundles the load/store request and response signals that pass between the
//   load/store unit and the byte-addressable data memory (memory_data_be).
//
// Signals:
//   rd_en       load request
//   rd_addr     load byte address
//   rd_funct3   RV32 load funct3 (LB/LH/LW/LBU/LHU)
//   rd_data     extended load result
//   rd_valid    rd_data holds the result of the load accepted on the last edge
//   wr_en       store request
//   wr_addr     store byte address
//   wr_funct3   RV32 store funct3 (SB/SH/SW)
//   wr_data     store data (low byte/half used for SB/SH)
//   busy        zero-clear sequence in progress, requests ignored
//   misalign    one-cycle pulse flagging a misaligned or illegal request
//
// Modports:
//   master  the load/store unit side (drives requests)
//   slave   the memory side (drives responses)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface memory_data_be_if;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [2:0]  rd_funct3;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [2:0]  wr_funct3;
    logic [31:0] wr_data;
    logic        busy;
    logic        misalign;

    modport master (
        output rd_en, rd_addr, rd_funct3,
        output wr_en, wr_addr, wr_funct3, wr_data,
        input  rd_data, rd_valid, busy, misalign
    );

    modport slave (
        input  rd_en, rd_addr, rd_funct3,
        input  wr_en, wr_addr, wr_funct3, wr_data,
        output rd_data, rd_valid, busy, misalign
    );
endinterface

// File: rtl/memory_data_be.sv
// -----------------------------------------------------------------------------
// memory_data_be
//
// Purpose:
//   Byte-addressable RV32 data memory for the MEM stage. Supports byte,
//   halfword and word stores through per-lane write enables, sign/zero
//   extending sub-word loads, misalignment / illegal-funct3 detection and an
//   optional zero-clear sequence that runs after every reset. Storage is one
//   read port plus one write port so it maps onto block RAM.
//
// Parameters:
//   WORD_ADDR_BITS  log2 of the depth in 32-bit words
//   CLEAR_ON_RESET  1: every reset zero-clears the whole array before
//                   requests are accepted; 0: reset leaves contents alone
//
// Ports:
//   clk   clock, everything on the rising edge
//   rst   synchronous active-high reset
//   bus   memory_data_be_if.slave, the load/store request/response bundle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module memory_data_be #(
    parameter int unsigned WORD_ADDR_BITS = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    memory_data_be_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** WORD_ADDR_BITS;
    localparam logic [WORD_ADDR_BITS-1:0] LAST_IDX = {WORD_ADDR_BITS{1'b1}};

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e                    state_q, state_d;
    logic [WORD_ADDR_BITS-1:0] clearIdx_q, clearIdx_d;

    logic [31:0] memArray_q [DEPTH];

    logic [31:0] rdWord_q;
    logic [1:0]  rdOff_q;
    logic [2:0]  rdFunct3_q;
    logic        rdValid_q;
    logic        misalign_q;

    logic [WORD_ADDR_BITS-1:0] rdIdx;
    logic [WORD_ADDR_BITS-1:0] wrIdx;
    logic [1:0]                rdOff;
    logic [1:0]                wrOff;
    logic                      acceptEn;
    logic                      loadLegal;
    logic                      storeLegal;
    logic                      loadAccept;
    logic                      storeAccept;
    logic                      faultNow;

    logic [3:0]                memWe;
    logic [WORD_ADDR_BITS-1:0] memIdx;
    logic [31:0]               memWdata;

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] rdData;

    logic unusedAddrBits;

    // Legal load encodings and their alignment demands: bytes are always
    // aligned, halves need bit 0 clear, words need both low bits clear.
    function automatic logic loadOk(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return ~off[0];
            3'b010:         return (off == 2'b00);
            default:        return 1'b0;
        endcase
    endfunction

    // Stores follow the same alignment rules but only have the three
    // unsigned-agnostic encodings.
    function automatic logic storeOk(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            3'b000:  return 1'b1;
            3'b001:  return ~off[0];
            3'b010:  return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Address bits above the word index only alias, so they are dropped here.
    assign rdIdx = bus.rd_addr[WORD_ADDR_BITS+1:2];
    assign wrIdx = bus.wr_addr[WORD_ADDR_BITS+1:2];
    assign rdOff = bus.rd_addr[1:0];
    assign wrOff = bus.wr_addr[1:0];

    assign unusedAddrBits = ^{bus.rd_addr[31:WORD_ADDR_BITS+2],
                              bus.wr_addr[31:WORD_ADDR_BITS+2]};

    // Requests are only honoured while ready and not being reset; a reset edge
    // swallows any request presented alongside it.
    assign acceptEn    = (state_q == ST_READY) && !rst;
    assign loadLegal   = loadOk(bus.rd_funct3, rdOff);
    assign storeLegal  = storeOk(bus.wr_funct3, wrOff);
    assign loadAccept  = acceptEn && bus.rd_en && loadLegal;
    assign storeAccept = acceptEn && bus.wr_en && storeLegal;
    assign faultNow    = acceptEn && ((bus.rd_en && !loadLegal) ||
                                      (bus.wr_en && !storeLegal));

    // State register for the clear sequencer. Reset always restarts the word
    // counter at zero, so a reset in the middle of a clear starts over.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET) begin
                state_q <= ST_CLEAR;
            end else begin
                state_q <= ST_READY;
            end
            clearIdx_q <= '0;
        end else begin
            state_q    <= state_d;
            clearIdx_q <= clearIdx_d;
        end
    end

    // Next-state logic: while clearing, step through every word and hand over
    // to READY right after the last word has been zeroed.
    always_comb begin
        state_d    = state_q;
        clearIdx_d = clearIdx_q;
        case (state_q)
            ST_CLEAR: begin
                clearIdx_d = clearIdx_q + WORD_ADDR_BITS'(1);
                if (clearIdx_q == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // The single write port is shared: the clear sequencer owns it while
    // clearing, otherwise an accepted store drives it. Sub-word store data is
    // replicated across lanes so the lane enables alone pick the target bytes.
    always_comb begin
        memWe    = 4'b0000;
        memIdx   = clearIdx_q;
        memWdata = 32'h0;
        if (!rst && (state_q == ST_CLEAR)) begin
            memWe = 4'b1111;
        end else if (storeAccept) begin
            memIdx = wrIdx;
            case (bus.wr_funct3[1:0])
                2'b00: begin
                    memWe    = 4'b0001 << wrOff;
                    memWdata = {4{bus.wr_data[7:0]}};
                end
                2'b01: begin
                    memWe    = wrOff[1] ? 4'b1100 : 4'b0011;
                    memWdata = {2{bus.wr_data[15:0]}};
                end
                default: begin
                    memWe    = 4'b1111;
                    memWdata = bus.wr_data;
                end
            endcase
        end
    end

    // Byte-lane write port of the storage array.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (memWe[lane]) begin
                memArray_q[memIdx][lane*8 +: 8] <= memWdata[lane*8 +: 8];
            end
        end
    end

    // Read port plus response registers. The array read is non-blocking so a
    // same-edge store to the same word is not visible yet (read-first). The
    // word, lane offset and funct3 only move on an accepted load, which is
    // what lets rd_data hold across idle and faulting cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdWord_q   <= 32'h0;
            rdOff_q    <= 2'b00;
            rdFunct3_q <= 3'b010;
            rdValid_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            rdValid_q  <= loadAccept;
            misalign_q <= faultNow;
            if (loadAccept) begin
                rdWord_q   <= memArray_q[rdIdx];
                rdOff_q    <= rdOff;
                rdFunct3_q <= bus.rd_funct3;
            end
        end
    end

    // Lane select and extension from the registered word. Only legal funct3
    // values are ever captured, so the default branch is the full word.
    always_comb begin
        laneByte = rdWord_q[{rdOff_q, 3'b000} +: 8];
        laneHalf = rdWord_q[{rdOff_q[1], 4'b0000} +: 16];
        rdData   = rdWord_q;
        case (rdFunct3_q)
            3'b000:  rdData = {{24{laneByte[7]}}, laneByte};
            3'b100:  rdData = {24'h0, laneByte};
            3'b001:  rdData = {{16{laneHalf[15]}}, laneHalf};
            3'b101:  rdData = {16'h0, laneHalf};
            default: rdData = rdWord_q;
        endcase
    end

    assign bus.rd_data  = rdData;
    assign bus.rd_valid = rdValid_q;
    assign bus.busy     = (state_q == ST_CLEAR);
    assign bus.misalign = misalign_q;

endmodule
